// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: user-side write/enable signals and display-side scan outputs
interface seg7_scan_ctrl_if;
    logic       en;
    logic       wr;
    logic [1:0] waddr;
    logic [2:0] wdata;
    logic [3:0] digit_mask;
    logic [2:0] val;
    logic [3:0] bits;
    logic [1:0] slot;
    logic       frame;
    modport master (output en, wr, waddr, wdata, digit_mask, input val, bits, slot, frame);
    modport slave (input en, wr, waddr, wdata, digit_mask, output val, bits, slot, frame);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 4-digit seven-segment scan with dead time between digits
module seg7_scan_ctrl #(
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 16
) (
    input logic clk,
    input logic rst,
    seg7_scan_ctrl_if.slave bus
);
    localparam int MX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int CW = (MX > 1) ? $clog2(MX) : 1;
    typedef enum logic [1:0] {OFF, BLANK, ON} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic [2:0] regs [4];
    logic [2:0] val;
    logic [1:0] slot;
    logic frame, blank_last, on_last;
    assign blank_last = cnt == CW'(BLANK_CYC - 1);
    assign on_last = cnt == CW'(DIV - 1);
    assign bus.val = val;
    assign bus.slot = slot;
    assign bus.frame = frame;
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= OFF;
        else state <= state_nxt;
    end
    // next state: enable drop always wins, otherwise alternate BLANK/ON phases
    always_comb begin
        state_nxt = !bus.en ? OFF :
                    state == OFF ? BLANK :
                    (state == BLANK && blank_last) ? ON :
                    (state == ON && on_last) ? BLANK : state;
    end
    // digit drive: only the scanned digit may go low, and only if unmasked
    always_comb begin
        bus.bits = (state == ON && bus.digit_mask[slot]) ? ~(4'b0001 << slot) : 4'b1111;
    end
    // register file, phase counter, slot and value capture; VAL moves only at BLANK entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            cnt <= '0;
            slot <= '0;
            val <= '0;
            frame <= 1'b0;
        end else begin
            if (bus.wr) regs[bus.waddr] <= bus.wdata;
            frame <= bus.en && state == ON && on_last && slot == 2'd3;
            if (!bus.en) begin
                slot <= '0;
                cnt <= '0;
            end else if (state == OFF) begin
                slot <= '0;
                cnt <= '0;
                val <= regs[0];
            end else if (state == BLANK) begin
                cnt <= blank_last ? '0 : cnt + 1'b1;
            end else if (on_last) begin
                cnt <= '0;
                slot <= slot + 2'd1;
                val <= regs[slot + 2'd1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for a 4-digit seven-segment display. Holds one 3-bit value per digit. Each value is presented in turn on the shared 3-bit input of the existing 3-to-7-segment decoder, while exactly one active-low digit enable (BITS) is asserted. A dead-time interval between digits prevents ghosting. The block sits between the user logic that writes digit values and the decoder/display pins.

Parameters:
DIV, 50000, clock cycles a digit stays lit per visit (ON phase); must be >= 1
BLANK_CYC, 16, clock cycles of all-digits-off dead time before each ON phase; must be >= 1

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous active-high reset
EN  input  1  scan enable; 0 forces display off
WR  input  1  write strobe for digit register file
WADDR  input  2  digit index to write (0..3)
WDATA  input  3  value to store (0..7, decoder input code)
DIGIT_MASK  input  4  per-digit enable; bit i = 0 keeps digit i dark during its slot
VAL  output  3  value driven to decoder inputs {A,B,C} (VAL[2]=A)
BITS  output  4  digit enables, active-low, at most one bit low
SLOT  output  2  index of digit currently being scanned
FRAME  output  1  one-cycle pulse when slot 3 ON phase completes

Behaviour:
- Clock and reset: one clock CLK. Reset RST is synchronous and active-high.
- Reset values:
  - State OFF.
  - BITS=4'b1111, VAL=0, SLOT=0, FRAME=0.
  - All four digit registers = 0.
  - Phase counter = 0.
- Register file:
  - On a CLK edge with WR=1, reg[WADDR] <= WDATA. Visible in reg the next cycle.
  - Writes are accepted in every state, including OFF.
- States: OFF, BLANK, ON. Phase counter width = clog2(max(DIV, BLANK_CYC)).
- OFF:
  - BITS=1111, FRAME=0.
  - If EN=1: go to BLANK with SLOT=0, counter=0, VAL<=reg[0].
- BLANK:
  - BITS=1111 for exactly BLANK_CYC cycles; VAL held.
  - On the last cycle: go to ON, counter=0.
- ON:
  - For exactly DIV cycles, BITS[SLOT]=~DIGIT_MASK[SLOT]; all other bits =1.
  - DIGIT_MASK is sampled combinationally each cycle, so a mask change takes effect immediately.
  - On the last cycle: SLOT<=SLOT+1 (mod 4, wraps 3->0), VAL<=reg[SLOT+1], go to BLANK.
  - If SLOT was 3, FRAME=1 on the cycle after that last ON cycle, for one cycle.
- VAL capture:
  - VAL changes only at BLANK entry, so the decoder has BLANK_CYC cycles to settle.
  - A write to the current slot during its BLANK/ON phase does not alter VAL. It appears on the next visit to that slot.
- Write timing: a write landing on the same edge as BLANK entry for that slot is not seen until the next visit. The old value is captured.
- Frame period: 4*(BLANK_CYC+DIV) cycles.
- EN deassert mid-operation:
  - State goes to OFF on the next edge; BITS=1111 from the next cycle.
  - SLOT<=0; VAL holds its last value.
  - Registers are preserved.
  - Re-assert restarts at slot 0 with a BLANK phase.
- RST mid-operation: overrides everything, including a simultaneous WR. All values return to reset values on that edge.
- Simultaneous EN=0 and WR: the write is performed and the state goes to OFF.
- Invariant: BITS never has more than one bit low. No cycle ever shows two different digits.

Test Plan:
1. Reset and write, then scan (DIV=4, BLANK_CYC=2):
   - Stimulus: RST, write reg0..3 = 1,2,3,4, then EN=1.
   - Required: after OFF, 2 cycles BITS=1111 with VAL=1, then 4 cycles BITS=1110.
   - Then 2 blank cycles, VAL=2, then BITS=1101 x4, and so on through BITS=0111 with VAL=4.
   - FRAME pulses once per 24 cycles.
2. Wrap-around: run 3 frames.
   - Required: SLOT sequence 0,1,2,3,0; VAL returns to 1 after slot 3.
   - Exactly 3 FRAME pulses, each 1 cycle wide.
3. Mask:
   - Stimulus: DIGIT_MASK=4'b1010.
   - Required: BITS stays 1111 during slots 0 and 2; BITS=1101 in slot 1 and 0111 in slot 3.
   - Timing and VAL sequence unchanged.
4. Write during own slot:
   - Stimulus: write reg1=7 while SLOT=1 in ON.
   - Required: VAL stays 2 for the rest of that visit; VAL=7 on the next visit to slot 1.
5. EN drop:
   - Stimulus: EN=0 mid-ON of slot 2.
   - Required: next cycle BITS=1111, SLOT=0, no FRAME.
   - Stimulus: EN=1 again.
   - Required: BLANK 2 cycles, then BITS=1110 with VAL=reg0.
6. RST mid-scan with WR=1:
   - Stimulus: assert RST and WR=1 together during scanning.
   - Required: all outputs return to reset values and registers read 0 (the write is dropped).
   - Checker throughout: BITS never has two or more bits low.
